// File: rtl/datapath_run_controller.sv
// Run/halt/single-step sequencer producing the cycle enable for the single-cycle datapath.
// Build macro BREAKPOINT_EN adds the PC breakpoint register, compare and skip-once logic.
//
// state   | meaning
// IDLE    | stopped, no halt reason recorded
// RUN     | free-running, cpu_en every cycle until a stop condition
// STEP    | running for step_left more instructions, host commands blocked
// HALTED  | stopped by command, halt opcode or breakpoint; counters frozen
module datapath_run_controller #(
    parameter logic [5:0] HALT_OPCODE = 6'b111111,
    parameter int         STEP_W      = 8
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [STEP_W-1:0] step_n,
    input  logic [31:0]       pc_in,
    input  logic [31:0]       instr_in,
    input  logic              bp_wr,
    input  logic [31:0]       bp_addr,
    output logic              cpu_en,
    output logic [1:0]        state,
    output logic [1:0]        halt_cause,
    output logic [31:0]       cycle_count,
    output logic [31:0]       retired
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_STEP   = 2'b10,
        ST_HALTED = 2'b11
    } state_t;

    localparam logic [1:0] OP_CLR  = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_HALT = 2'b10;
    localparam logic [1:0] OP_STEP = 2'b11;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_CMD  = 2'b01;
    localparam logic [1:0] CAUSE_OPC  = 2'b10;
    localparam logic [1:0] CAUSE_BP   = 2'b11;

    state_t            st;
    logic [STEP_W-1:0] step_left;
    logic [STEP_W-1:0] step_first;
    logic              accepted;
    logic              cmd_clr;
    logic              cmd_run;
    logic              cmd_halt;
    logic              cmd_step;
    logic              opcode_hit;
    logic              bp_hit;
    logic              stop;
    logic              active;
    logic [1:0]        stop_cause;
    logic              unused_inputs;

    assign state      = st;
    assign cmd_ready  = (st != ST_STEP);
    assign accepted   = cmd_valid & cmd_ready;
    assign cmd_clr    = accepted & (cmd_op == OP_CLR);
    assign cmd_run    = accepted & (cmd_op == OP_RUN);
    assign cmd_halt   = accepted & (cmd_op == OP_HALT);
    assign cmd_step   = accepted & (cmd_op == OP_STEP);
    assign step_first = (step_n == '0) ? STEP_W'(1) : step_n;

    assign opcode_hit = (instr_in[31:26] == HALT_OPCODE);
    assign stop       = opcode_hit | bp_hit | cmd_halt | cmd_clr;
    assign active     = (st == ST_RUN) | (st == ST_STEP);

    // Zero-latency enable: the halting instruction itself must never be executed.
    assign cpu_en     = active & ~stop & ~Reset;

    // A host HALT only names the cause when nothing in the program stopped it.
    assign stop_cause = opcode_hit ? CAUSE_OPC :
                        bp_hit     ? CAUSE_BP  :
                                     CAUSE_CMD;

`ifdef BREAKPOINT_EN
    logic [31:0] bp_reg;
    logic        bp_armed;
    logic        skip_bp;

    // Compare sees the register contents from before any same-cycle bp_wr.
    assign bp_hit        = bp_armed & (pc_in == bp_reg) & ~skip_bp;
    assign unused_inputs = ^instr_in[25:0];

    always_ff @(posedge clock) begin
        if (Reset) begin
            bp_reg   <= '0;
            bp_armed <= 1'b0;
        end else if (bp_wr) begin
            bp_reg   <= bp_addr;
            bp_armed <= 1'b1;
        end
    end

    // Resuming from a breakpoint lets that PC through exactly once.
    always_ff @(posedge clock) begin
        if (Reset) begin
            skip_bp <= 1'b0;
        end else if (st == ST_HALTED && (cmd_run || cmd_step)) begin
            skip_bp <= 1'b1;
        end else if (cpu_en || cmd_clr) begin
            skip_bp <= 1'b0;
        end
    end
`else
    assign bp_hit        = 1'b0;
    assign unused_inputs = ^{bp_wr, bp_addr, pc_in, instr_in[25:0]};
`endif

    always_ff @(posedge clock) begin
        if (Reset) begin
            st          <= ST_IDLE;
            halt_cause  <= CAUSE_NONE;
            cycle_count <= '0;
            retired     <= '0;
            step_left   <= '0;
        end else begin
            if (cpu_en) begin
                retired <= retired + 32'd1;
            end
            if (active) begin
                cycle_count <= cycle_count + 32'd1;
            end

            case (st)
                ST_IDLE, ST_HALTED: begin
                    if (cmd_run) begin
                        st         <= ST_RUN;
                        halt_cause <= CAUSE_NONE;
                    end else if (cmd_step) begin
                        st         <= ST_STEP;
                        step_left  <= step_first;
                        halt_cause <= CAUSE_NONE;
                    end else if (cmd_halt) begin
                        st         <= ST_HALTED;
                        halt_cause <= CAUSE_CMD;
                    end else if (cmd_clr) begin
                        st          <= ST_IDLE;
                        halt_cause  <= CAUSE_NONE;
                        cycle_count <= '0;
                        retired     <= '0;
                    end
                end

                ST_RUN: begin
                    if (cmd_clr) begin
                        st          <= ST_IDLE;
                        halt_cause  <= CAUSE_NONE;
                        cycle_count <= '0;
                        retired     <= '0;
                    end else if (stop) begin
                        st         <= ST_HALTED;
                        halt_cause <= stop_cause;
                    end else if (cmd_step) begin
                        st        <= ST_STEP;
                        step_left <= step_first;
                    end
                end

                ST_STEP: begin
                    if (stop) begin
                        st         <= ST_HALTED;
                        halt_cause <= stop_cause;
                    end else begin
                        step_left <= step_left - STEP_W'(1);
                        if (step_left <= STEP_W'(1)) begin
                            st         <= ST_HALTED;
                            halt_cause <= CAUSE_CMD;
                        end
                    end
                end

                default: begin
                    st <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
